// File: rtl/fetch_unit.sv
// Instruction-fetch controller: issues imem requests at the current PC and buffers returned words for decode.
// Optional sticky error reporting is built only when FETCH_ERR_CHECK_EN is defined.
module fetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_enable,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);

  logic          epoch_q, epoch_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] stale_q, stale_d;
  logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [32:0]   tag_mem_q [MAX_OUTST];
  logic [FW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   buf_mem_q [FIFO_DEPTH];

  logic        credit_ok, fire, rsp_pop, rsp_keep, if_pop;
  logic [32:0] tag_head;
  logic [63:0] buf_head;

  assign tag_head = tag_mem_q[tag_rd_q];
  assign buf_head = buf_mem_q[buf_rd_q];

  // Credits cover both in-flight requests and buffered words, so every response finds a free slot.
  assign credit_ok = (int'(outst_q) < MAX_OUTST) &&
                     (int'(outst_q) + int'(count_q) < FIFO_DEPTH);

  assign imem_req_valid = !rst && (pc != 32'd0) && !redirect_valid && credit_ok && (stale_q == '0);
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign pc_enable      = !rst && (pc != 32'd0) && (redirect_valid || fire);
  assign pc_next        = redirect_valid ? redirect_pc : pc + 32'd4;

  assign rsp_pop  = !rst && imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_pop && !redirect_valid && (stale_q == '0) && (tag_head[32] == epoch_q);

  assign if_valid = !rst && (count_q != '0) && !redirect_valid;
  assign if_pop   = if_valid && if_ready;
  assign if_pc    = buf_head[63:32];
  assign if_instr = buf_head[31:0];

  always_comb begin
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    outst_d  = outst_q;
    stale_d  = stale_q;
    epoch_d  = epoch_q;
    buf_wr_d = buf_wr_q;
    buf_rd_d = buf_rd_q;
    count_d  = count_q;

    if (fire)
      tag_wr_d = (tag_wr_q == TW'(MAX_OUTST - 1)) ? '0 : tag_wr_q + TW'(1);
    if (rsp_pop)
      tag_rd_d = (tag_rd_q == TW'(MAX_OUTST - 1)) ? '0 : tag_rd_q + TW'(1);

    unique case ({fire, rsp_pop})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    if (rsp_pop && (stale_q != '0))
      stale_d = stale_q - OW'(1);

    // Everything still in flight after a redirect is stale; issue waits until it has drained.
    if (redirect_valid) begin
      epoch_d  = ~epoch_q;
      stale_d  = outst_d;
      buf_wr_d = '0;
      buf_rd_d = '0;
      count_d  = '0;
    end else begin
      if (rsp_keep) buf_wr_d = buf_wr_q + FW'(1);
      if (if_pop)   buf_rd_d = buf_rd_q + FW'(1);
      unique case ({rsp_keep, if_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q  <= 1'b0;
      outst_q  <= '0;
      stale_q  <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
      count_q  <= '0;
    end else begin
      epoch_q  <= epoch_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      buf_wr_q <= buf_wr_d;
      buf_rd_q <= buf_rd_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire)     tag_mem_q[tag_wr_q] <= {epoch_q, pc};
    if (rsp_keep) buf_mem_q[buf_wr_q] <= {tag_head[31:0], imem_rsp_data};
  end

`ifdef FETCH_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (imem_rsp_valid && (outst_q == '0))
      err_d = 1'b1;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign fetch_err = !rst && err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model plus an in-order imem and PC register, driven by directed and random cycles.
module tb_fetch_unit;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUTST  = 2;
`ifdef FETCH_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] pc, pc_next, imem_req_addr, imem_rsp_data, redirect_pc, if_instr, if_pc;
  logic        pc_enable, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, if_valid, if_ready, fetch_err;

  fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_enable(pc_enable), .pc_next(pc_next),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fetch_err(fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { bit stale; logic [31:0] pc; } tag_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  tag_t  outq[$];
  ent_t  bufq[$];
  mreq_t memq[$];
  logic [31:0] pc_log[$];
  logic [31:0] ins_log[$];

  logic [31:0] m_pc;
  bit          m_err;
  int          cyc, lat_min, lat_max, total, bad, dut_fires;
  logic        obs_req_valid, obs_pc_en, obs_if_valid, obs_err;
  logic [31:0] obs_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  // One clock cycle: memory/PC environment drives inputs, outputs are checked mid-cycle, then the model advances.
  task automatic applyStimulus(input bit r, input bit redir, input logic [31:0] rpc,
                               input bit ifr, input bit rr, input bit spur);
    bit          rsp_v, stale_any, e_req, e_fire, e_pc_en, e_ifv, e_err;
    logic [31:0] rsp_d, e_next;
    int          n_out, n_buf;
    tag_t        t;
    ent_t        e;
    mreq_t       m;

    rsp_v = 1'b0;
    rsp_d = $urandom;
    if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = instr_of(memq[0].addr);
      memq.delete(0);
    end else if (!r && spur && memq.size() == 0) begin
      rsp_v = 1'b1;
    end

    rst            = r;
    pc             = m_pc;
    imem_req_ready = rr;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if_ready       = ifr;
    #3;

    n_out = outq.size();
    n_buf = bufq.size();
    stale_any = 1'b0;
    foreach (outq[i]) if (outq[i].stale) stale_any = 1'b1;
    e_req   = !r && m_pc != 32'd0 && !redir && n_out < MAX_OUTST &&
              (n_out + n_buf) < FIFO_DEPTH && !stale_any;
    e_fire  = e_req && rr;
    e_pc_en = !r && m_pc != 32'd0 && (redir || e_fire);
    e_next  = redir ? rpc : m_pc + 32'd4;
    e_ifv   = !r && n_buf > 0 && !redir;
    e_err   = ERR_ON && !r && m_err;

    checkOutput("req_valid", 64'(imem_req_valid), 64'(e_req));
    if (e_req) checkOutput("req_addr", 64'(imem_req_addr), 64'(m_pc));
    checkOutput("pc_enable", 64'(pc_enable), 64'(e_pc_en));
    if (e_pc_en) checkOutput("pc_next", 64'(pc_next), 64'(e_next));
    checkOutput("if_valid", 64'(if_valid), 64'(e_ifv));
    if (e_ifv) checkOutput("if_head", {if_pc, if_instr}, {bufq[0].pc, bufq[0].instr});
    checkOutput("fetch_err", 64'(fetch_err), 64'(e_err));

    obs_req_valid = imem_req_valid;
    obs_addr      = imem_req_addr;
    obs_pc_en     = pc_enable;
    obs_if_valid  = if_valid;
    obs_err       = fetch_err;
    if (imem_req_valid && imem_req_ready) dut_fires++;
    if (if_valid && if_ready) begin
      pc_log.push_back(if_pc);
      ins_log.push_back(if_instr);
    end

    if (r) begin
      outq.delete();
      bufq.delete();
      memq.delete();
      m_err = 1'b0;
      m_pc  = 32'd0;
    end else begin
      if (rsp_v && n_out > 0) begin
        t = outq[0];
        outq.delete(0);
        if (!t.stale && !redir) begin
          e.pc    = t.pc;
          e.instr = rsp_d;
          bufq.push_back(e);
        end
      end
      if (e_ifv && ifr) bufq.delete(0);
      if (redir) begin
        bufq.delete();
        foreach (outq[i]) outq[i].stale = 1'b1;
      end
      if (e_fire) begin
        t.stale = 1'b0;
        t.pc    = m_pc;
        outq.push_back(t);
        m.due  = cyc + int'($urandom_range(lat_max, lat_min));
        m.addr = m_pc;
        memq.push_back(m);
      end
      if ((rsp_v && n_out == 0) || (redir && rpc[1:0] != 2'b00)) m_err = 1'b1;
      if (m_pc == 32'd0)  m_pc = 32'h8000_0000;
      else if (e_pc_en)   m_pc = e_next;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          found;

    total = 0; bad = 0; cyc = 0; dut_fires = 0;
    m_pc = 32'd0; m_err = 1'b0; lat_min = 1; lat_max = 1;
    rst = 1'b1; pc = 32'd0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
    @(posedge clk);
    #1;

    // Bring-up: sequential fetch from the reset vector with latency-1 memory.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_req", 64'(obs_req_valid), 64'd0);
    checkOutput("reset_ifv", 64'(obs_if_valid), 64'd0);
    pc_log.delete(); ins_log.delete();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("no_req_pc0", 64'(obs_req_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("first_addr", 64'(obs_addr), 64'h8000_0000);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("boot_count", 64'(pc_log.size() >= 3), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (pc_log.size() > i) begin
        checkOutput("boot_if_pc", 64'(pc_log[i]), 64'(32'h8000_0000 + 32'(4 * i)));
        checkOutput("boot_if_instr", 64'(ins_log[i]), 64'(instr_of(32'h8000_0000 + 32'(4 * i))));
      end
    end

    // Decode stalled: only FIFO_DEPTH requests may go out, then everything drains in order.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    dut_fires = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_fires", 64'(dut_fires), 64'(FIFO_DEPTH));
    checkOutput("stall_req", 64'(obs_req_valid), 64'd0);
    checkOutput("stall_pc_en", 64'(obs_pc_en), 64'd0);
    pc_log.delete(); ins_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("drain_count", 64'(pc_log.size() >= 2), 64'd1);
    if (pc_log.size() >= 2) begin
      checkOutput("drain_pc0", 64'(pc_log[0]), 64'h8000_0000);
      checkOutput("drain_pc1", 64'(pc_log[1]), 64'h8000_0004);
    end

    // Memory backpressure: address and PC hold, one fire on release.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("hold_addr", 64'(obs_addr), 64'h8000_0000);
      checkOutput("hold_pc_en", 64'(obs_pc_en), 64'd0);
    end
    dut_fires = 0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("release_fire", 64'(dut_fires), 64'd1);

    // Redirect with two requests in flight at latency 3.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    lat_min = 3; lat_max = 3; dut_fires = 0;
    for (int i = 0; i < 10 && dut_fires < 2; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("two_fires", 64'(dut_fires), 64'd2);
    pc_log.delete(); ins_log.delete();
    applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("redir_first_pc", 64'(pc_log.size() > 0 ? pc_log[0] : 32'd0), 64'h8000_0100);

    // Response beat coincides with a redirect.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    lat_min = 2; lat_max = 2; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        applyStimulus(1'b0, 1'b1, 32'h8000_0200, 1'b1, 1'b1, 1'b0);
        checkOutput("rsp_redir_ifv", 64'(obs_if_valid), 64'd0);
        found = 1'b1;
      end else begin
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      end
    end
    checkOutput("rsp_redir_seen", 64'(found), 64'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

    // PC wrap from 0xFFFF_FFFC back to zero, after which the PC reloads the boot address.
    lat_min = 1; lat_max = 1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    pc_log.delete(); ins_log.delete();
    applyStimulus(1'b0, 1'b1, 32'hffff_fff8, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_count", 64'(pc_log.size() >= 3), 64'd1);
    if (pc_log.size() >= 3) begin
      checkOutput("wrap_pc1", 64'(pc_log[1]), 64'hffff_fffc);
      checkOutput("wrap_pc2", 64'(pc_log[2]), 64'h8000_0000);
    end

    // Error flag: spurious beat, stickiness, clear on reset, misaligned redirect.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("err_spurious", 64'(obs_err), 64'(ERR_ON));
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("err_sticky", 64'(obs_err), 64'(ERR_ON));
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("err_in_reset", 64'(obs_err), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("err_cleared", 64'(obs_err), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0102, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("err_misalign", 64'(obs_err), 64'(ERR_ON));

    // Randomized traffic against the model with varying latency and handshake pressure.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    for (int ph = 0; ph < 6; ph++) begin
      lat_min = 1;
      lat_max = 1 + (ph % 4);
      for (int c = 0; c < 250; c++) begin
        rpc = 32'h8000_0000 + 32'($urandom_range(255, 0)) * 32'd4;
        if ($urandom_range(29, 0) == 0) rpc = 32'hffff_fff0;
        if ($urandom_range(19, 0) == 0) rpc[1:0] = 2'b10;
        applyStimulus($urandom_range(199, 0) == 0, $urandom_range(99, 0) < 6, rpc,
                      $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 70,
                      $urandom_range(49, 0) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
